// File: rtl/scell_pkg.sv
// scell_pkg: bitline state encoding and voltage bands shared with the cell model
package scell_pkg;
  typedef enum logic [1:0] {DATA_TRUE, DATA_FALSE, INDET} state_data_e;
  localparam real TRUE_MIN  = 1.3;
  localparam real TRUE_MAX  = 2.2;
  localparam real FALSE_MIN = -0.5;
  localparam real FALSE_MAX = 0.7;
endpackage

// File: rtl/sram_sense_rd_pkg.sv
// sram_sense_rd_pkg: read FSM states and counter widths
package sram_sense_rd_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, RECOVER, RESP} rd_state_e;
  localparam int CNT_W   = 4;
  localparam int RETRY_W = 3;
endpackage

// File: rtl/sram_sense_rd_if.sv
// sram_sense_rd_if: read request/response bus plus wordline and bitline pair
interface sram_sense_rd_if #(parameter int ROWS = 8);
  localparam int AW = $clog2(ROWS) + 1;
  logic rd_req;
  logic [AW-1:0] rd_addr;
  logic rd_ready;
  logic [ROWS-1:0] row_rd;
  real bl_rd;
  real blb_rd;
  logic rd_valid;
  logic rd_ack;
  logic rd_data;
  logic rd_err;
  modport master(output rd_req, rd_addr, rd_ack, bl_rd, blb_rd,
                 input rd_ready, row_rd, rd_valid, rd_data, rd_err);
  modport slave(input rd_req, rd_addr, rd_ack, bl_rd, blb_rd,
                output rd_ready, row_rd, rd_valid, rd_data, rd_err);
endinterface

// File: rtl/sram_sense_rd_bl_classify.sv
// bl_classify: maps the read bitline pair to TRUE/FALSE/indeterminate
module bl_classify
  import scell_pkg::*;
(
  input  real         bl_rd,
  input  real         blb_rd,
  output state_data_e cls
);
  logic bl_t, bl_f, blb_t, blb_f;
  always_comb begin
    bl_t  = bl_rd >= TRUE_MIN && bl_rd <= TRUE_MAX;
    bl_f  = bl_rd >= FALSE_MIN && bl_rd <= FALSE_MAX;
    blb_t = blb_rd >= TRUE_MIN && blb_rd <= TRUE_MAX;
    blb_f = blb_rd >= FALSE_MIN && blb_rd <= FALSE_MAX;
    cls   = bl_t && blb_f ? DATA_TRUE : bl_f && blb_t ? DATA_FALSE : INDET;
  end
endmodule

// File: rtl/sram_sense_rd.sv
// sram_sense_rd: drives one read wordline, senses the bitline pair, retries on indeterminate samples
module sram_sense_rd
  import scell_pkg::*;
  import sram_sense_rd_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 1
) (
  input logic clk,
  input logic rst,
  sram_sense_rd_if.slave bus
);
  localparam int AW = $clog2(ROWS) + 1;
  rd_state_e state;
  logic [AW-1:0] addr;
  logic [CNT_W-1:0] cnt;
  logic [RETRY_W-1:0] retry;
  state_data_e cls;
  logic last;
  bl_classify u_cls (.bl_rd(bus.bl_rd), .blb_rd(bus.blb_rd), .cls(cls));
  assign last = cnt == CNT_W'(SETTLE_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      cnt          <= '0;
      retry        <= '0;
      bus.rd_ready <= 1'b0;
      bus.row_rd   <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= 1'b0;
      bus.rd_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.rd_ready <= 1'b1;
          if (bus.rd_req && bus.rd_ready) begin
            bus.rd_ready <= 1'b0;
            addr         <= bus.rd_addr;
            cnt          <= '0;
            retry        <= '0;
            // out-of-range rows never touch the wordlines
            if (bus.rd_addr >= AW'(ROWS)) begin
              state        <= RESP;
              bus.rd_valid <= 1'b1;
              bus.rd_err   <= 1'b1;
              bus.rd_data  <= 1'b0;
            end else begin
              state      <= DRIVE;
              bus.row_rd <= ROWS'(1) << bus.rd_addr;
            end
          end
        end
        DRIVE: begin
          if (last) begin
            bus.row_rd <= '0;
            cnt        <= '0;
            if (cls != INDET) begin
              state        <= RESP;
              bus.rd_valid <= 1'b1;
              bus.rd_data  <= cls == DATA_TRUE;
              bus.rd_err   <= 1'b0;
            end else if (retry != RETRY_W'(MAX_RETRY)) begin
              state <= RECOVER;
              retry <= retry + 1'b1;
            end else begin
              state        <= RESP;
              bus.rd_valid <= 1'b1;
              bus.rd_data  <= 1'b0;
              bus.rd_err   <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        end
        RECOVER: begin
          state      <= DRIVE;
          bus.row_rd <= ROWS'(1) << addr;
        end
        RESP: begin
          if (bus.rd_ack) begin
            state        <= IDLE;
            bus.rd_ready <= 1'b1;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= 1'b0;
            bus.rd_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_sense_rd.sv
// tb_sram_sense_rd: table-driven reads with a latency/result scoreboard plus handshake and reset sequences
module tb_sram_sense_rd;
  localparam int ROWS = 8;
  localparam int S    = 2;
  localparam int MR   = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;
  sram_sense_rd_if #(.ROWS(ROWS)) bus ();
  sram_sense_rd #(.ROWS(ROWS), .SETTLE_CYC(S), .MAX_RETRY(MR)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int addr;
    int bl1;
    int blb1;
    int bl2;
    int blb2;
    int d;
    int e;
    int lat;
  } vec_t;
  typedef struct {
    int d;
    int e;
    int lat;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[10];
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_bl(input int bl_mv, input int blb_mv);
    bus.bl_rd  = real'(bl_mv) / 1000.0;
    bus.blb_rd = real'(blb_mv) / 1000.0;
  endtask
  task automatic run(input vec_t v);
    int k;
    int row_exp;
    exp_t ex;
    exp_t got;
    chk("ready_before_req", int'(bus.rd_ready), 1);
    bus.rd_addr = 4'(v.addr);
    set_bl(v.bl1, v.blb1);
    bus.rd_req = 1'b1;
    ex.d = v.d;
    ex.e = v.e;
    ex.lat = v.lat;
    sb.push_back(ex);
    tick();
    bus.rd_req = 1'b0;
    k = 0;
    while (!bus.rd_valid && k < 40) begin
      row_exp = v.addr >= ROWS ? 0 : (k % (S + 1) < S ? 1 << v.addr : 0);
      chk("row_rd", int'(bus.row_rd), row_exp);
      tick();
      k++;
      if (k == S) set_bl(v.bl2, v.blb2);
    end
    got = sb.pop_front();
    if (k >= 40) begin
      chk("valid_timeout", k, got.lat);
    end else begin
      chk("latency", k, got.lat);
      chk("rd_data", int'(bus.rd_data), got.d);
      chk("rd_err", int'(bus.rd_err), got.e);
      chk("row_rd_resp", int'(bus.row_rd), 0);
      tick();
      chk("hold_valid", int'(bus.rd_valid), 1);
      chk("hold_data", int'(bus.rd_data), got.d);
      chk("hold_err", int'(bus.rd_err), got.e);
      bus.rd_ack = 1'b1;
      tick();
      bus.rd_ack = 1'b0;
      chk("valid_after_ack", int'(bus.rd_valid), 0);
      chk("ready_after_ack", int'(bus.rd_ready), 1);
    end
  endtask
  initial begin
    tbl[0] = '{5, 1500, 0, 1500, 0, 1, 0, S};
    tbl[1] = '{0, 200, 1800, 200, 1800, 0, 0, S};
    tbl[2] = '{7, 1300, 700, 1300, 700, 1, 0, S};
    tbl[3] = '{2, 2210, 0, 2210, 0, 0, 1, 2 * S + 1};
    tbl[4] = '{3, 1500, 1500, 1500, 1500, 0, 1, 2 * S + 1};
    tbl[5] = '{1, 1000, 1000, 1000, 1000, 0, 1, 2 * S + 1};
    tbl[6] = '{4, 1000, 0, 1500, 0, 1, 0, 2 * S + 1};
    tbl[7] = '{6, -500, 2200, -500, 2200, 0, 0, S};
    tbl[8] = '{9, 1500, 0, 1500, 0, 0, 1, 0};
    tbl[9] = '{1, 710, 2000, 710, 2000, 0, 1, 2 * S + 1};
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    bus.rd_ack = 1'b0;
    set_bl(0, 0);
    repeat (3) tick();
    chk("rst_ready", int'(bus.rd_ready), 0);
    chk("rst_valid", int'(bus.rd_valid), 0);
    chk("rst_row", int'(bus.row_rd), 0);
    chk("rst_data", int'(bus.rd_data), 0);
    chk("rst_err", int'(bus.rd_err), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", int'(bus.rd_ready), 1);
    for (int i = 0; i < 10; i++) run(tbl[i]);
    // ack held high: leave RESP after one cycle, back-to-back request one cycle later
    bus.rd_ack = 1'b1;
    bus.rd_addr = 4'd0;
    set_bl(200, 1800);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    repeat (S) tick();
    chk("b2b_valid", int'(bus.rd_valid), 1);
    chk("b2b_data", int'(bus.rd_data), 0);
    tick();
    chk("b2b_idle_valid", int'(bus.rd_valid), 0);
    chk("b2b_idle_ready", int'(bus.rd_ready), 1);
    bus.rd_ack = 1'b0;
    bus.rd_addr = 4'd5;
    set_bl(1500, 0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("b2b_accept_ready", int'(bus.rd_ready), 0);
    chk("b2b_row", int'(bus.row_rd), 32);
    repeat (S) tick();
    chk("b2b2_valid", int'(bus.rd_valid), 1);
    chk("b2b2_data", int'(bus.rd_data), 1);
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    // reset in the second DRIVE cycle aborts the read
    bus.rd_addr = 4'd3;
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    chk("abort_row_pre", int'(bus.row_rd), 8);
    rst = 1'b1;
    tick();
    chk("abort_row", int'(bus.row_rd), 0);
    chk("abort_valid", int'(bus.rd_valid), 0);
    chk("abort_ready", int'(bus.rd_ready), 0);
    rst = 1'b0;
    tick();
    chk("abort_ready_rise", int'(bus.rd_ready), 1);
    repeat (4) tick();
    chk("abort_discard", int'(bus.rd_valid), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
